// File: rtl/cacheline_adapter.sv
// cacheline_adapter: turns one 256-bit cache line read/write into a 4-beat
// 64-bit burst on the main-memory side, then pulses pmem_resp for one cycle.
//
// Handshake: a cache request (pmem_read/pmem_write) is held until pmem_resp;
// a burst strobe (burst_read/burst_write) is held for the whole burst and a
// beat moves only in a cycle where burst_resp=1 while the strobe is high.
module cacheline_adapter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [31:0]       pmem_address,
  input  logic [LINE_W-1:0] pmem_wdata,
  output logic [LINE_W-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic              burst_read,
  output logic              burst_write,
  output logic [31:0]       burst_address,
  output logic [BEAT_W-1:0] burst_wdata,
  input  logic [BEAT_W-1:0] burst_rdata,
  input  logic              burst_resp,
  output logic [1:0]        dbg_state,
  output logic [1:0]        dbg_beat
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          beat_q, beat_d;
  logic [LINE_W-1:0]   line_q, line_d;    // assembled read line
  logic [LINE_W-1:0]   wline_q, wline_d;  // latched write line
  logic [31:0]         addr_q, addr_d;

  // Line offset bits are not part of the burst address.
  logic unused_addr_bits;
  assign unused_addr_bits = ^pmem_address[4:0];

  // State, beat counter, line buffers and latched address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= 2'd0;
      line_q  <= '0;
      wline_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      wline_q <= wline_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic: accept in IDLE (write has priority), count beats, finish in DONE.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    line_d  = line_q;
    wline_d = wline_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (pmem_write) begin
          addr_d  = {pmem_address[31:5], 5'b0};
          wline_d = pmem_wdata;
          beat_d  = 2'd0;
          state_d = S_WRITE;
        end else if (pmem_read) begin
          addr_d  = {pmem_address[31:5], 5'b0};
          beat_d  = 2'd0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (burst_resp) begin
          line_d[int'(beat_q)*BEAT_W +: BEAT_W] = burst_rdata;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = S_DONE;
        end
      end
      S_WRITE: begin
        if (burst_resp) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes and response decode from state only; write beat is a slice of the latched line.
  always_comb begin
    burst_read    = (state_q == S_READ);
    burst_write   = (state_q == S_WRITE);
    pmem_resp     = (state_q == S_DONE);
    burst_wdata   = '0;
    if (state_q == S_WRITE) burst_wdata = wline_q[int'(beat_q)*BEAT_W +: BEAT_W];
    burst_address = addr_q;
    pmem_rdata    = line_q;
    dbg_state     = state_q;
    dbg_beat      = beat_q;
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Testbench for cacheline_adapter: directed steps plus randomized line
// transactions, checked against a transaction-level model of the adapter.
module tb_cacheline_adapter;

  logic         clk;
  logic         rst;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         burst_read;
  logic         burst_write;
  logic [31:0]  burst_address;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;
  logic [1:0]   dbg_state;
  logic [1:0]   dbg_beat;

  int passed = 0;
  int total  = 0;

  // Model state: the line the adapter should currently present on pmem_rdata,
  // and the per-beat wait-state counts the memory side inserts.
  logic [255:0] exp_line;
  int           waits[4];

  cacheline_adapter dut (
    .clk           (clk),
    .rst           (rst),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_address  (pmem_address),
    .pmem_wdata    (pmem_wdata),
    .pmem_rdata    (pmem_rdata),
    .pmem_resp     (pmem_resp),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_address (burst_address),
    .burst_wdata   (burst_wdata),
    .burst_rdata   (burst_rdata),
    .burst_resp    (burst_resp),
    .dbg_state     (dbg_state),
    .dbg_beat      (dbg_beat)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are then observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One line transaction. Called in an IDLE cycle; returns while observing the
  // pmem_resp cycle. 'line' is the write line, or the data memory returns for a read.
  // Expected completion is 5 cycles plus one per inserted wait state.
  task automatic run_txn(input bit is_wr, input bit hold_rd,
                         input logic [31:0] addr, input logic [255:0] line);
    int          exp_cycles;
    int          beats_done;
    int          wait_left;
    logic [2:0]  exp_str;
    logic [31:0] exp_addr;
    exp_cycles = 5 + waits[0] + waits[1] + waits[2] + waits[3];
    exp_addr   = {addr[31:5], 5'b0};
    pmem_address = addr;
    pmem_write   = is_wr;
    pmem_read    = !is_wr || hold_rd;
    pmem_wdata   = is_wr ? line : rand_line();
    beats_done = 0;
    wait_left  = waits[0];
    for (int c = 1; c <= exp_cycles; c++) begin
      step();
      // Later address/data changes on the cache side must not leak in.
      pmem_address = $urandom;
      if (is_wr) pmem_wdata = rand_line();
      exp_str = (beats_done < 4) ? (is_wr ? 3'b001 : 3'b010) : 3'b100;
      chk("strobes", {pmem_resp, burst_read, burst_write}, exp_str);
      burst_resp  = 1'b0;
      burst_rdata = {$urandom, $urandom};
      if (beats_done < 4) begin
        chk("burst_address", burst_address, exp_addr);
        if (is_wr) chk("burst_wdata", burst_wdata, line[beats_done*64 +: 64]);
        if (wait_left > 0) begin
          wait_left--;
        end else begin
          burst_resp = 1'b1;
          if (!is_wr) burst_rdata = line[beats_done*64 +: 64];
          beats_done++;
          if (beats_done < 4) wait_left = waits[beats_done];
        end
      end else begin
        if (!is_wr) exp_line = line;
        chk("pmem_rdata", pmem_rdata, exp_line);
        pmem_write = 1'b0;
        pmem_read  = hold_rd;
      end
    end
    burst_resp = 1'b0;
  endtask

  // The cycle after pmem_resp must be an IDLE cycle with the beat counter at 0.
  task automatic idle_gap();
    step();
    chk("idle_strobes", {pmem_resp, burst_read, burst_write}, 3'b000);
    chk("idle_beat", dbg_beat, 2'd0);
  endtask

  task automatic set_waits(input int w0, input int w1, input int w2, input int w3);
    waits[0] = w0;
    waits[1] = w1;
    waits[2] = w2;
    waits[3] = w3;
  endtask

  // Directed and randomized stimulus sequence.
  initial begin
    logic [255:0] line;
    logic [31:0]  addr;
    rst          = 1'b1;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    burst_rdata  = '0;
    burst_resp   = 1'b0;
    exp_line     = '0;
    set_waits(0, 0, 0, 0);

    // Reset held two cycles: every output at zero.
    step();
    step();
    chk("rst_strobes", {pmem_resp, burst_read, burst_write}, 3'b000);
    chk("rst_rdata", pmem_rdata, '0);
    chk("rst_baddr", burst_address, '0);
    chk("rst_wdata", burst_wdata, '0);
    chk("rst_beat", dbg_beat, 2'd0);
    rst = 1'b0;

    // burst_resp pulses while idle must be ignored.
    for (int i = 0; i < 3; i++) begin
      burst_resp  = 1'b1;
      burst_rdata = {$urandom, $urandom};
      step();
      chk("idle_ignore_strobes", {pmem_resp, burst_read, burst_write}, 3'b000);
      chk("idle_ignore_rdata", pmem_rdata, '0);
      chk("idle_ignore_beat", dbg_beat, 2'd0);
    end
    burst_resp = 1'b0;
    step();

    // Read with no wait states at the given address.
    set_waits(0, 0, 0, 0);
    run_txn(1'b0, 1'b0, 32'h1234_567F,
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    chk("read_line_value", exp_line,
        {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    idle_gap();

    // Write with burst_resp on alternating cycles; read line must not change.
    set_waits(1, 1, 1, 1);
    run_txn(1'b1, 1'b0, 32'hA5A5_0F13,
            {128'hFFEE_DDCC_BBAA_9988_7766_5544_3322_1100,
             128'hFFEE_DDCC_BBAA_9988_7766_5544_3322_1100});
    idle_gap();

    // Write and read both requested: write first, then the still-held read.
    set_waits($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
    run_txn(1'b1, 1'b1, $urandom, rand_line());
    idle_gap();
    set_waits($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
    run_txn(1'b0, 1'b0, $urandom, rand_line());
    idle_gap();

    // Back-to-back: read issued right after a write completes.
    set_waits(0, 2, 0, 1);
    run_txn(1'b1, 1'b0, 32'h0000_1FE0, rand_line());
    idle_gap();
    set_waits(0, 0, 0, 0);
    run_txn(1'b0, 1'b0, 32'hFFFF_FFE4, rand_line());
    idle_gap();

    // Randomized mix of line reads and writes with random wait states.
    for (int n = 0; n < 8; n++) begin
      set_waits($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      run_txn(1'($urandom_range(0, 1)), 1'b0, $urandom, rand_line());
      idle_gap();
    end

    // Reset while beat 2 of a read is on the bus.
    addr = 32'hCAFE_F00D;
    line = rand_line();
    pmem_address = addr;
    pmem_read    = 1'b1;
    for (int b = 0; b < 3; b++) begin
      step();
      chk("rstmid_strobes", {pmem_resp, burst_read, burst_write}, 3'b010);
      burst_resp  = 1'b1;
      burst_rdata = line[b*64 +: 64];
    end
    rst = 1'b1;
    step();
    rst        = 1'b0;
    pmem_read  = 1'b0;
    burst_resp = 1'b0;
    exp_line   = '0;
    chk("rstmid_after_strobes", {pmem_resp, burst_read, burst_write}, 3'b000);
    chk("rstmid_rdata", pmem_rdata, exp_line);
    chk("rstmid_baddr", burst_address, '0);
    chk("rstmid_wdata", burst_wdata, '0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rstmid_no_resp", {pmem_resp, burst_read, burst_write}, 3'b000);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
